// File: rtl/packet_header_deserializer_if.sv
// ============================================================================
// packet_header_deserializer_if : byte stream in, parallel 5-tuple header out
// Rev 1.0
// ============================================================================
`default_nettype none

interface packet_header_deserializer_if #(
  parameter int IP_SIZE       = 32,
  parameter int PORT_SIZE     = 16,
  parameter int PROTOCOL_SIZE = 8
);
  logic [7:0]               s_data;
  logic                     s_valid;
  logic                     s_last;
  logic                     s_ready;
  logic [IP_SIZE-1:0]       m_src_ip;
  logic [PORT_SIZE-1:0]     m_src_port;
  logic [IP_SIZE-1:0]       m_dst_ip;
  logic [PORT_SIZE-1:0]     m_dst_port;
  logic [PROTOCOL_SIZE-1:0] m_protocol;
  logic                     m_valid;
  logic                     m_ready;

  // Environment side: drives the byte stream, consumes headers.
  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_src_ip, m_src_port, m_dst_ip, m_dst_port, m_protocol, m_valid
  );

  // Deserializer side.
  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_src_ip, m_src_port, m_dst_ip, m_dst_port, m_protocol, m_valid
  );
endinterface

`default_nettype wire

// File: rtl/packet_header_deserializer.sv
// ============================================================================
// packet_header_deserializer : assembles a 5-tuple header from an 8-bit stream
// Rev 1.0
// ============================================================================
`default_nettype none

module packet_header_deserializer #(
  parameter int IP_SIZE       = 32,
  parameter int PORT_SIZE     = 16,
  parameter int PROTOCOL_SIZE = 8,
  parameter int CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  packet_header_deserializer_if.slave   bus,
  output logic                          err_short,
  output logic                          err_long,
  output logic [CNT_W-1:0]              short_cnt,
  output logic [CNT_W-1:0]              long_cnt
);

  localparam int HDR_BITS  = 2*IP_SIZE + 2*PORT_SIZE + PROTOCOL_SIZE;
  localparam int HDR_BYTES = HDR_BITS / 8;
  localparam int IDX_W     = $clog2(HDR_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BYTES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SKIP    = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [HDR_BITS-9:0]   sh_q, sh_d;
  logic [HDR_BITS-1:0]   hdr_q, hdr_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;
  logic [CNT_W-1:0]      short_cnt_q, short_cnt_d;
  logic [CNT_W-1:0]      long_cnt_q, long_cnt_d;

  logic                  accept;
  logic [HDR_BITS-1:0]   full_hdr;

  assign accept   = bus.s_valid && s_ready_q;
  // The byte on the bus completes the header when it is the last one.
  assign full_hdr = {sh_q, bus.s_data};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    hdr_d       = hdr_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    short_cnt_d = short_cnt_q;
    long_cnt_d  = long_cnt_q;

    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          sh_d = {sh_q[HDR_BITS-17:0], bus.s_data};
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.s_last) begin
              hdr_d   = full_hdr;
              state_d = ST_OUT;
            end else begin
              state_d = ST_SKIP;
            end
          end else if (bus.s_last) begin
            idx_d       = '0;
            err_short_d = 1'b1;
            short_cnt_d = (&short_cnt_q) ? short_cnt_q : short_cnt_q + CNT_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SKIP: begin
        if (accept && bus.s_last) begin
          err_long_d = 1'b1;
          long_cnt_d = (&long_cnt_q) ? long_cnt_q : long_cnt_q + CNT_W'(1);
          idx_d      = '0;
          state_d    = ST_COLLECT;
        end
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          idx_d   = '0;
          state_d = ST_COLLECT;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_COLLECT;
      end
    endcase

    // Handshake outputs are flops decoded from the next state.
    s_ready_d = (state_d != ST_OUT);
    m_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      idx_q       <= '0;
      sh_q        <= '0;
      hdr_q       <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      short_cnt_q <= '0;
      long_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      hdr_q       <= hdr_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      short_cnt_q <= short_cnt_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_src_ip   = hdr_q[HDR_BITS-1 -: IP_SIZE];
  assign bus.m_src_port = hdr_q[HDR_BITS-IP_SIZE-1 -: PORT_SIZE];
  assign bus.m_dst_ip   = hdr_q[HDR_BITS-IP_SIZE-PORT_SIZE-1 -: IP_SIZE];
  assign bus.m_dst_port = hdr_q[PORT_SIZE+PROTOCOL_SIZE-1 -: PORT_SIZE];
  assign bus.m_protocol = hdr_q[PROTOCOL_SIZE-1:0];

  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign short_cnt = short_cnt_q;
  assign long_cnt  = long_cnt_q;

endmodule

`default_nettype wire
